mips_alu_unit: RTL and testbench
================================

// Module: mips_alu_unit
// PURPOSE
//  MIPS single-cycle-style execute block. It merges the ALU-control decoder with a
//  32-bit ALU that has a registered output. ALUop from the main controller and the
//  R-type funct field select the operation on srcA/srcB. The result and zero flag
//  are registered and feed the writeback/branch logic.
// PARAMETERS
//  WIDTH  32  datapath width of operands and result
// PORTS
//  clk_i        in   1      single clock; all state updates on rising edge
//  rst_i        in   1      reset, asynchronous, active-high
//  srcA_i       in   WIDTH  operand A
//  srcB_i       in   WIDTH  operand B
//  ALUop_i      in   2      00=add (lw/sw), 01=sub (beq), 10=R-type (use funct), 11=reserved
//  funct_i      in   6      R-type funct field; ignored unless ALUop_i==10
//  aluControl_o out  3      decoded ALU control (combinational, debug/observability)
//  aluResult_o  out  WIDTH  registered ALU result
//  zero_o       out  1      registered flag, 1 when the registered result == 0
// BEHAVIOUR
//  Decode (combinational, no latency):
//   ALUop 00 -> 010 add; ALUop 01 -> 110 sub; ALUop 11 -> 010 add.
//   ALUop 10: funct 100000->010 add, 100010->110 sub, 100100->000 and,
//    100101->001 or, 101010->111 slt; any other funct -> 010 add.
//  Operations on control code:
//   010 A+B (mod 2^WIDTH, carry discarded); 110 A-B (mod 2^WIDTH);
//   000 A&B; 001 A|B; 111 slt: 1 if $signed(A)<$signed(B), else 0, zero-extended;
//   unused codes 011/100/101 -> result 0.
//  Timing: result computed combinationally from current inputs, captured at each
//   rising clk_i edge. Latency is 1 cycle. No enable and no handshake; the output
//   updates every cycle.
//  zero_o is registered in the same flop stage as aluResult_o, so it is always
//   consistent with aluResult_o.
//  Reset: asserting rst_i immediately forces aluResult_o=0 and zero_o=1, regardless
//   of the clock. After deassertion, the first rising edge captures the live result.
//  aluControl_o is not reset; it follows the inputs combinationally.
//  X/undriven inputs before first drive: outputs are don't-care until rst_i or a
//   clock edge with defined inputs.
//  Overflow is not flagged. Wrap-around is silent (0xFFFFFFFF+1 -> 0, zero_o=1).
// STRUCTURE
//  Package mips_alu_pkg:
//   - typedef enum logic[1:0] aluop_e {ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE, ALUOP_RSVD}
//   - typedef enum logic[2:0] alu_ctrl_e {AND=000, OR=001, ADD=010, SUB=110, SLT=111}
//   - localparam funct constants: F_ADD, F_SUB, F_AND, F_OR, F_SLT
//  Sub-module alu_control_decoder: pure combinational ALUop/funct -> alu_ctrl_e.
//  Top mips_alu_unit: instantiates the decoder, plus an operation mux, plus the
//   result/zero register with async reset.
// TESTING
//  1. Reset: rst_i=1 mid-run -> aluResult_o=0 and zero_o=1 with no clock edge;
//     both hold until release.
//  2. A=9, B=2, ALUop=00 -> aluControl_o=010, next edge aluResult_o=0xB, zero_o=0;
//     ALUop=01 -> 110, result 0x7.
//  3. A=0x16, B=0x4, ALUop=10 with funct 100010/100100/100101 -> results
//     0x12 / 0x4 / 0x16 on successive edges.
//  4. slt: A=0x10, B=0x10 -> 0, zero_o=1; A=0xFFFFFFFF, B=1 -> 1 (signed);
//     A=1, B=0xFFFFFFFF -> 0.
//  5. Defaults: ALUop=10 with funct=000000 -> 010 add; ALUop=11 -> 010 add;
//     A=9, B=2 -> 0xB.
//  6. Wrap/zero: A=0xFFFFFFFF, B=1, add -> 0, zero_o=1; A=5, B=5, sub -> 0,
//     zero_o=1; latency is exactly 1 edge.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared types and funct encodings for the MIPS execute block.
// Control codes follow the classic MIPS ALU-control mapping.
package mips_alu_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_e;

    typedef enum logic [2:0] {
        AND = 3'b000,
        OR  = 3'b001,
        ADD = 3'b010,
        SUB = 3'b110,
        SLT = 3'b111
    } alu_ctrl_e;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

endpackage

// File: rtl/mips_alu_control_decoder.sv
// Combinational ALUop/funct decoder producing the 3-bit ALU control code.
// Reserved ALUop and unknown funct values fall back to add.
module alu_control_decoder
    import mips_alu_pkg::*;
(
    input  aluop_e    aluop,
    input  logic [5:0] funct,
    output alu_ctrl_e alu_ctrl
);

    always_comb begin
        alu_ctrl = ADD;
        case (aluop)
            ALUOP_ADD: alu_ctrl = ADD;
            ALUOP_SUB: alu_ctrl = SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    F_ADD:   alu_ctrl = ADD;
                    F_SUB:   alu_ctrl = SUB;
                    F_AND:   alu_ctrl = AND;
                    F_OR:    alu_ctrl = OR;
                    F_SLT:   alu_ctrl = SLT;
                    default: alu_ctrl = ADD;
                endcase
            end
            default: alu_ctrl = ADD;
        endcase
    end

endmodule

// File: rtl/mips_alu_unit.sv
// MIPS execute block: ALU-control decode, operation mux and a single
// result/zero register stage with asynchronous active-high reset.
module mips_alu_unit
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] srcA_i,
    input  logic [WIDTH-1:0] srcB_i,
    input  logic [1:0]       ALUop_i,
    input  logic [5:0]       funct_i,
    output logic [2:0]       aluControl_o,
    output logic [WIDTH-1:0] aluResult_o,
    output logic             zero_o
);

    alu_ctrl_e        alu_ctrl;
    logic [WIDTH-1:0] result_d;
    logic             slt_bit;

    alu_control_decoder u_dec (
        .aluop    (aluop_e'(ALUop_i)),
        .funct    (funct_i),
        .alu_ctrl (alu_ctrl)
    );

    assign aluControl_o = alu_ctrl;
    assign slt_bit      = $signed(srcA_i) < $signed(srcB_i);

    // Codes the decoder never emits (011/100/101) yield zero.
    always_comb begin
        result_d = '0;
        case (alu_ctrl)
            ADD:     result_d = srcA_i + srcB_i;
            SUB:     result_d = srcA_i - srcB_i;
            AND:     result_d = srcA_i & srcB_i;
            OR:      result_d = srcA_i | srcB_i;
            SLT:     result_d = {{(WIDTH-1){1'b0}}, slt_bit};
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aluResult_o <= '0;
            zero_o      <= 1'b1;
        end else begin
            aluResult_o <= result_d;
            zero_o      <= (result_d == '0);
        end
    end

endmodule

// File: tb/tb_mips_alu_unit.sv
// Scoreboard bench for mips_alu_unit: directed and random vectors against
// an arithmetic reference model, with a decoupled monitor on the output.
module tb_mips_alu_unit;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        string       tag;
    } exp_t;

    logic        clk_tb = 1'b0;
    logic        rst_tb;
    logic [31:0] src_a, src_b;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_miss = 0;

    mips_alu_unit #(.WIDTH(32)) dut (
        .clk_i        (clk_tb),
        .rst_i        (rst_tb),
        .srcA_i       (src_a),
        .srcB_i       (src_b),
        .ALUop_i      (aluop),
        .funct_i      (funct),
        .aluControl_o (alu_ctrl),
        .aluResult_o  (alu_result),
        .zero_o       (zero)
    );

    always #5 clk_tb = ~clk_tb;

    // Reference: choose the operation by name, then do plain arithmetic.
    function automatic logic [2:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'd1) return 3'b110;
        if (op != 2'd2) return 3'b010;
        if (f == 6'd32) return 3'b010;
        if (f == 6'd34) return 3'b110;
        if (f == 6'd36) return 3'b000;
        if (f == 6'd37) return 3'b001;
        if (f == 6'd42) return 3'b111;
        return 3'b010;
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] c, input logic [31:0] a,
                                               input logic [31:0] b);
        longint la, lb;
        la = longint'({32'd0, a});
        lb = longint'({32'd0, b});
        if (c == 3'b010) return 32'((la + lb) % 64'h1_0000_0000);
        if (c == 3'b110) return 32'((la - lb + 64'h1_0000_0000) % 64'h1_0000_0000);
        if (c == 3'b000) return a & b;
        if (c == 3'b001) return a | b;
        if (c == 3'b111) return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        return 32'd0;
    endfunction

    task automatic apply(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [5:0] f, input string tag);
        exp_t e;
        logic [2:0] c;
        @(negedge clk_tb);
        src_a = a; src_b = b; aluop = op; funct = f;
        #1;
        c = ref_ctrl(op, f);
        n_vec++;
        if (alu_ctrl !== c) begin
            n_miss++;
            $display("FAIL ctrl_%s: got %b expected %b", tag, alu_ctrl, c);
        end
        e.res  = ref_result(c, a, b);
        e.zero = (e.res == 32'd0);
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        if (alu_result !== 32'd0 || zero !== 1'b1) begin
            n_miss++;
            $display("FAIL %s: got result=%h zero=%b expected result=0 zero=1",
                     tag, alu_result, zero);
        end
    endtask

    // Monitor: output is presented every edge while out of reset.
    always @(posedge clk_tb) begin
        exp_t e;
        #1;
        if (!rst_tb && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (alu_result !== e.res) begin
                n_miss++;
                $display("FAIL result_%s: got %h expected %h", e.tag, alu_result, e.res);
            end
            if (zero !== e.zero) begin
                n_miss++;
                $display("FAIL zero_%s: got %b expected %b", e.tag, zero, e.zero);
            end
        end
    end

    initial begin
        logic [5:0]  fset [6];
        logic [31:0] specials [5];
        logic [31:0] ra, rb;
        int          drain;
        fset     = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};

        rst_tb = 1'b1;
        src_a = 32'd0; src_b = 32'd0; aluop = 2'd0; funct = 6'd0;
        #2;
        n_vec++;
        check_reset_state("reset_initial");
        @(negedge clk_tb);
        rst_tb = 1'b0;

        apply(32'd9, 32'd2, 2'b00, 6'd0, "add_9_2");
        apply(32'd9, 32'd2, 2'b01, 6'd0, "sub_9_2");
        apply(32'h16, 32'h4, 2'b10, 6'b100010, "r_sub");
        apply(32'h16, 32'h4, 2'b10, 6'b100100, "r_and");
        apply(32'h16, 32'h4, 2'b10, 6'b100101, "r_or");
        apply(32'h16, 32'h4, 2'b10, 6'b100000, "r_add");
        apply(32'h10, 32'h10, 2'b10, 6'b101010, "slt_eq");
        apply(32'hFFFF_FFFF, 32'd1, 2'b10, 6'b101010, "slt_neg");
        apply(32'd1, 32'hFFFF_FFFF, 2'b10, 6'b101010, "slt_pos");
        apply(32'd9, 32'd2, 2'b10, 6'b000000, "dflt_funct");
        apply(32'd9, 32'd2, 2'b11, 6'b101010, "rsvd_op");
        apply(32'hFFFF_FFFF, 32'd1, 2'b00, 6'd0, "wrap_add");
        apply(32'd5, 32'd5, 2'b01, 6'd0, "sub_zero");
        apply(32'h1234_5678, 32'h0000_0001, 2'b01, 6'd0, "lat_after_zero");

        // Mid-run asynchronous reset, asserted between edges with no clock edge.
        @(posedge clk_tb);
        #3;
        src_a = 32'hDEAD_BEEF; src_b = 32'h1; aluop = 2'b00;
        rst_tb = 1'b1;
        #1;
        n_vec++;
        check_reset_state("reset_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_tb);
            n_vec++;
            check_reset_state("reset_hold");
        end
        #2;
        rst_tb = 1'b0;
        exp_q.delete();

        apply(32'd9, 32'd2, 2'b00, 6'd0, "post_reset");

        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom();
            rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom();
            if ($urandom_range(0, 7) == 0) rb = ra;
            apply(ra, rb, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0) ? 6'($urandom()) : fset[$urandom_range(0, 5)],
                  "random");
        end

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk_tb);
            drain++;
        end
        #2;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
